mem_dump_reader: RTL and testbench

//  On-chip reader for the single_cycle_mips data memory. Watches the CPU

---
 rtl/mips_dbg_pkg.sv | 10 +
 rtl/halt_detect.sv | 35 +++
 rtl/mem_dump_reader.sv | 88 ++++++++
 tb/tb_mem_dump_reader.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mips_dbg_pkg.sv
// mips_dbg_pkg: shared FSM state type, halt defaults and datamem address helper
package mips_dbg_pkg;
  typedef enum logic [1:0] {RUN, FETCH, PRESENT, DONE} state_t;
  localparam int NOP_LIMIT_DEF = 9;
  localparam int WATCHDOG_DEF = 500;
  localparam int NUM_WORDS_DEF = 22;
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [7:0] idx, input logic [1:0] b);
    return base + {22'd0, idx, 2'b00} + {30'd0, b};
  endfunction
endpackage

// File: rtl/halt_detect.sv
// halt_detect: saturating NOP-run and watchdog counters that flag the CPU halt
module halt_detect #(
  parameter int NOP_LIMIT = 9,
  parameter int WATCHDOG = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] inst,
  output logic        halt,
  output logic        wd
);
  localparam int NW = $clog2(NOP_LIMIT + 1);
  localparam int CW = $clog2(WATCHDOG);
  logic [NW-1:0] nop_cnt;
  logic [CW-1:0] cyc_cnt;
  logic zero, nop_hit, wd_hit;
  assign zero = inst == 32'd0;
  assign nop_hit = zero && nop_cnt >= NW'(NOP_LIMIT - 1);
  assign wd_hit = cyc_cnt == CW'(WATCHDOG - 1);
  assign halt = en && (nop_hit || wd_hit);
  assign wd = en && wd_hit && !nop_hit;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nop_cnt <= '0;
      cyc_cnt <= '0;
    end else if (!en) begin
      nop_cnt <= '0;
      cyc_cnt <= '0;
    end else begin
      nop_cnt <= !zero ? '0 : nop_cnt == NW'(NOP_LIMIT) ? nop_cnt : nop_cnt + 1'b1;
      cyc_cnt <= wd_hit ? cyc_cnt : cyc_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mem_dump_reader.sv
// mem_dump_reader: on CPU halt, freezes the CPU and streams big-endian datamem words out
module mem_dump_reader
  import mips_dbg_pkg::*;
#(
  parameter int NOP_LIMIT = NOP_LIMIT_DEF,
  parameter int WATCHDOG = WATCHDOG_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  output logic        cpu_hold,
  output logic        mem_sel,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_byte,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_data,
  output logic [7:0]  dump_index,
  output logic        done,
  output logic        halted_wd,
  input  logic        rearm
);
  state_t state;
  logic [1:0] byte_cnt;
  logic [7:0] word_idx;
  logic [31:0] shreg;
  logic halt, wd;
  halt_detect #(.NOP_LIMIT(NOP_LIMIT), .WATCHDOG(WATCHDOG)) u_halt (
    .clk(clk),
    .rst_n(rst_n),
    .en(state == RUN),
    .inst(inst),
    .halt(halt),
    .wd(wd)
  );
  assign mem_addr = word_addr(32'(BASE_ADDR), word_idx, byte_cnt);
  assign mem_sel = cpu_hold;
  assign dump_data = shreg;
  assign dump_index = word_idx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      byte_cnt <= '0;
      word_idx <= '0;
      shreg <= '0;
      halted_wd <= 1'b0;
      cpu_hold <= 1'b0;
      dump_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        RUN: if (halt) begin
          state <= FETCH;
          halted_wd <= wd;
          cpu_hold <= 1'b1;
        end
        FETCH: begin
          shreg <= {shreg[23:0], mem_byte};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            state <= PRESENT;
            dump_valid <= 1'b1;
          end
        end
        PRESENT: if (dump_ready) begin
          dump_valid <= 1'b0;
          if (word_idx == 8'(NUM_WORDS - 1)) begin
            state <= DONE;
            done <= 1'b1;
          end else begin
            word_idx <= word_idx + 8'd1;
            state <= FETCH;
          end
        end
        DONE: if (rearm) begin
          state <= RUN;
          done <= 1'b0;
          halted_wd <= 1'b0;
          cpu_hold <= 1'b0;
          word_idx <= '0;
          shreg <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_dump_reader.sv
// tb_mem_dump_reader: directed tests with a per-cycle word/index scoreboard for mem_dump_reader
module tb_mem_dump_reader;
  localparam int NUM_WORDS = 22;
  logic clk = 0, rst_n = 0, dump_ready = 0, rearm = 0;
  logic [31:0] inst = 32'h20080005;
  logic cpu_hold, mem_sel, dump_valid, done, halted_wd;
  logic [31:0] mem_addr, dump_data;
  logic [7:0] mem_byte, dump_index;
  logic [7:0] mem [256];
  int n_chk = 0, n_fail = 0, exp_idx = 0, n;
  bit prev_hs = 0;
  always #5 clk = ~clk;
  assign mem_byte = mem[mem_addr[7:0]];
  mem_dump_reader dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .cpu_hold(cpu_hold), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_byte(mem_byte), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_index(dump_index), .done(done), .halted_wd(halted_wd), .rearm(rearm)
  );
  function automatic logic [31:0] word(input int i);
    return {mem[4*i], mem[4*i+1], mem[4*i+2], mem[4*i+3]};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_idx = 0;
      prev_hs = 0;
    end else begin
      chk("sel_eq_hold", {31'd0, mem_sel}, {31'd0, cpu_hold});
      if (!cpu_hold) exp_idx = 0;
      if (prev_hs) chk("no_back_to_back", {31'd0, dump_valid}, 32'd0);
      if (dump_valid) begin
        chk("sb_index", {24'd0, dump_index}, exp_idx);
        chk("sb_data", dump_data, word(exp_idx));
        chk("sb_hold_in_dump", {31'd0, cpu_hold}, 32'd1);
      end
      if (done) begin
        chk("done_words", exp_idx, NUM_WORDS);
        chk("done_no_valid", {31'd0, dump_valid}, 32'd0);
      end
      prev_hs = dump_valid && dump_ready;
      if (prev_hs) exp_idx++;
    end
  end
  task automatic wait_halt(input int exp_n);
    while (!cpu_hold && n < 2000) begin
      tick;
      n++;
    end
    chk("halt_cycles", n, exp_n);
  endtask
  task automatic run_dump(input bit rnd);
    int k = 0;
    while (!done && k < 3000) begin
      dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick;
      k++;
    end
    dump_ready = 0;
    chk("dump_done", {31'd0, done}, 32'd1);
    chk("dump_handshakes", exp_idx, NUM_WORDS);
  endtask
  task automatic do_rearm;
    rearm = 1;
    tick;
    rearm = 0;
    chk("rearm_done", {31'd0, done}, 32'd0);
    chk("rearm_hold", {31'd0, cpu_hold}, 32'd0);
    chk("rearm_wd", {31'd0, halted_wd}, 32'd0);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
    #3;
    chk("rst_outs", {cpu_hold, mem_sel, dump_valid, done, halted_wd}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_data", dump_data, 32'd0);
    tick;
    rst_n = 1;
    repeat (3) tick;
    inst = 0;
    n = 0;
    wait_halt(9);
    chk("nop_wd", {31'd0, halted_wd}, 32'd0);
    n = 0;
    while (!dump_valid && n < 20) begin
      tick;
      n++;
    end
    chk("first_valid_lat", n, 4);
    chk("first_data", dump_data, 32'h12345678);
    chk("first_index", {24'd0, dump_index}, 32'd0);
    repeat (5) begin
      tick;
      chk("stall_valid", {31'd0, dump_valid}, 32'd1);
      chk("stall_data", dump_data, 32'h12345678);
      chk("stall_index", {24'd0, dump_index}, 32'd0);
    end
    dump_ready = 1;
    tick;
    dump_ready = 0;
    chk("valid_drop", {31'd0, dump_valid}, 32'd0);
    run_dump(1);
    inst = 32'h20080005;
    do_rearm;
    n = 0;
    wait_halt(500);
    chk("wd_flag", {31'd0, halted_wd}, 32'd1);
    n = 0;
    while (!dump_valid && n < 20) begin
      tick;
      n++;
    end
    rearm = 1;
    tick;
    rearm = 0;
    chk("rearm_ignored_valid", {31'd0, dump_valid}, 32'd1);
    chk("rearm_ignored_hold", {31'd0, cpu_hold}, 32'd1);
    run_dump(0);
    inst = 32'h20080005;
    do_rearm;
    repeat (491) tick;
    inst = 0;
    n = 491;
    wait_halt(500);
    chk("both_wd", {31'd0, halted_wd}, 32'd0);
    run_dump(1);
    do_rearm;
    n = 0;
    wait_halt(9);
    repeat (2) tick;
    chk("fetch_addr", mem_addr, 32'd2);
    #2;
    rst_n = 0;
    #1;
    chk("async_outs", {cpu_hold, mem_sel, dump_valid, done, halted_wd}, 32'd0);
    chk("async_addr", mem_addr, 32'd0);
    chk("async_data", dump_data, 32'd0);
    tick;
    tick;
    rst_n = 1;
    chk("post_rst_hold", {31'd0, cpu_hold}, 32'd0);
    n = 0;
    wait_halt(9);
    run_dump(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
